// File: rtl/axis_capture_buffer_if.sv
// AXI4-Stream bundle used by axis_capture_buffer.
//   tdata  : DWIDTH-bit payload
//   tvalid : source has a beat
//   tready : sink accepts the beat
//   tlast  : final beat of a packet (the slave side does not use it)
// Modports: master drives tdata/tvalid/tlast and samples tready; slave is the reverse.
interface axis_capture_buffer_if #(
  parameter int unsigned DWIDTH = 128
) ();
  logic [DWIDTH-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_capture_buffer.sv
// Triggered AXI4-Stream capture buffer.
// After an arm request, a rising edge on trig_i stores DEPTH consecutive valid beats into a
// simple dual-port RAM. The beats are then replayed in order on m_axis with full backpressure
// and tlast on the final beat.
//
// Ports:
//   clk_i, rst_i : clock and asynchronous active-high reset
//   arm_i        : arm request, honoured only in IDLE
//   trig_i       : trigger level; only its rising edge matters
//   abort_i      : return to IDLE from any state, clearing the readout pipeline
//   s_axis       : capture stream (slave); tready is always 1
//   m_axis       : readout stream (master)
//   state_o      : 0=IDLE 1=ARMED 2=CAPTURE 3=READOUT
//   done_o       : one-cycle pulse after the final readout handshake
//
// Build option: define CAPBUF_AUTO_REARM_EN to return to ARMED rather than IDLE after a
// complete readout.
module axis_capture_buffer #(
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned DWIDTH = 128
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  arm_i,
  input  logic                  trig_i,
  input  logic                  abort_i,
  axis_capture_buffer_if.slave  s_axis,
  axis_capture_buffer_if.master m_axis,
  output logic [1:0]            state_o,
  output logic                  done_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);
  localparam logic [AW:0]   IssueEnd = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StCapture = 2'd2,
    StReadout = 2'd3
  } state_e;

  state_e            state_q;
  logic              trig_q;
  logic [AW-1:0]     wptr_q;
  logic [AW:0]       issue_cnt_q;  // RAM reads issued during this readout
  logic              rd_pend_q;    // a RAM read returns data this cycle
  logic              rd_last_q;
  logic [DWIDTH-1:0] rd_data_q;
  logic              skid_valid_q;
  logic              skid_last_q;
  logic [DWIDTH-1:0] skid_data_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic [DWIDTH-1:0] out_data_q;
  logic              done_q;

  logic [DWIDTH-1:0] mem [DEPTH];

  logic          trig_edge;
  logic          wr_en;
  logic          pop;
  logic [1:0]    occ;
  logic          room;
  logic          rd_issue;
  logic [AW-1:0] rd_addr;

  assign trig_edge = trig_i & ~trig_q;
  assign wr_en     = s_axis.tvalid & ~abort_i &
                     (((state_q == StArmed) & trig_edge) | (state_q == StCapture));
  assign pop       = out_valid_q & m_axis.tready;

  // Beats held in the output/skid registers plus any read still in flight. A new read is only
  // issued if its data is guaranteed a slot, so the two registers never overflow.
  assign occ       = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, rd_pend_q};
  assign room      = (occ < 2'd2) | ((occ == 2'd2) & pop);
  assign rd_issue  = (state_q == StReadout) & (issue_cnt_q != IssueEnd) & room & ~abort_i;
  assign rd_addr   = issue_cnt_q[AW-1:0];

  // Block RAM: contents are not reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wptr_q] <= s_axis.tdata;
    end
    if (rd_issue) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      trig_q       <= 1'b0;
      wptr_q       <= '0;
      issue_cnt_q  <= '0;
      rd_pend_q    <= 1'b0;
      rd_last_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_last_q  <= 1'b0;
      skid_data_q  <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
      done_q       <= 1'b0;
    end else begin
      trig_q <= trig_i;
      done_q <= 1'b0;
      if (abort_i) begin
        state_q      <= StIdle;
        wptr_q       <= '0;
        issue_cnt_q  <= '0;
        rd_pend_q    <= 1'b0;
        rd_last_q    <= 1'b0;
        skid_valid_q <= 1'b0;
        skid_last_q  <= 1'b0;
        out_valid_q  <= 1'b0;
        out_last_q   <= 1'b0;
      end else begin
        // Readout pipeline: RAM read -> output register, with the skid register catching the
        // returning beat when the output register is stalled.
        rd_pend_q <= rd_issue;
        if (rd_issue) begin
          rd_last_q   <= (rd_addr == LastAddr);
          issue_cnt_q <= issue_cnt_q + 1'b1;
        end
        if (!out_valid_q || pop) begin
          if (skid_valid_q) begin
            out_valid_q  <= 1'b1;
            out_data_q   <= skid_data_q;
            out_last_q   <= skid_last_q;
            skid_valid_q <= rd_pend_q;
            skid_last_q  <= rd_pend_q & rd_last_q;
            if (rd_pend_q) begin
              skid_data_q <= rd_data_q;
            end
          end else begin
            out_valid_q <= rd_pend_q;
            out_last_q  <= rd_pend_q & rd_last_q;
            if (rd_pend_q) begin
              out_data_q <= rd_data_q;
            end
          end
        end else if (rd_pend_q) begin
          skid_valid_q <= 1'b1;
          skid_data_q  <= rd_data_q;
          skid_last_q  <= rd_last_q;
        end

        unique case (state_q)
          StIdle: begin
            // A trigger edge coinciding with arm is deliberately not captured.
            if (arm_i) begin
              state_q <= StArmed;
            end
          end
          StArmed: begin
            if (trig_edge) begin
              state_q <= StCapture;
              if (s_axis.tvalid) begin
                wptr_q <= wptr_q + 1'b1;
              end
            end
          end
          StCapture: begin
            if (s_axis.tvalid) begin
              wptr_q <= wptr_q + 1'b1;  // wraps to 0 after the last address
              if (wptr_q == LastAddr) begin
                state_q <= StReadout;
              end
            end
          end
          StReadout: begin
            if (pop && out_last_q) begin
              done_q      <= 1'b1;
              issue_cnt_q <= '0;
`ifdef CAPBUF_AUTO_REARM_EN
              state_q     <= StArmed;
`else
              state_q     <= StIdle;
`endif
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign s_axis.tready = 1'b1;
  assign m_axis.tdata  = out_data_q;
  assign m_axis.tvalid = out_valid_q;
  assign m_axis.tlast  = out_last_q;
  assign state_o       = state_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_axis_capture_buffer.sv
// Directed bench for axis_capture_buffer with DEPTH=16. Each task drives one scenario and checks
// its own results against hand-derived values.
module tb_axis_capture_buffer;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned DWIDTH = 128;
`ifdef CAPBUF_AUTO_REARM_EN
  localparam logic [1:0] EndState = 2'd1;
`else
  localparam logic [1:0] EndState = 2'd0;
`endif

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       arm_i = 1'b0;
  logic       trig_i = 1'b0;
  logic       abort_i = 1'b0;
  logic [1:0] state_o;
  logic       done_o;

  axis_capture_buffer_if #(.DWIDTH(DWIDTH)) s_if ();
  axis_capture_buffer_if #(.DWIDTH(DWIDTH)) m_if ();

  axis_capture_buffer #(
    .DEPTH  (DEPTH),
    .DWIDTH (DWIDTH)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .arm_i   (arm_i),
    .trig_i  (trig_i),
    .abort_i (abort_i),
    .s_axis  (s_if),
    .m_axis  (m_if),
    .state_o (state_o),
    .done_o  (done_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [DWIDTH-1:0] rx[$];
  logic              rx_last[$];
  int                done_cnt, stall_viol, cycles, first_valid;
  logic              done_end, done_after;
  logic [1:0]        state_end;

  function automatic logic [DWIDTH-1:0] mk(input int v);
    logic [15:0] s;
    s = v[15:0];
    return {8{s}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; arm_i = 1'b0; trig_i = 1'b0; abort_i = 1'b0;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0; m_if.tready = 1'b0;
    step(); step();
    rst_i = 1'b0;
    step();
  endtask

  task automatic arm();
    arm_i = 1'b1;
    step();
    arm_i = 1'b0;
  endtask

  // Expects ARMED with trig_i low beforehand; the first beat coincides with the trigger edge.
  task automatic capture(input int base, input bit gapped);
    for (int k = 0; k < int'(DEPTH); k++) begin
      trig_i = 1'b1; s_if.tvalid = 1'b1; s_if.tdata = mk(base + k);
      step();
      if (gapped && k != int'(DEPTH) - 1) begin
        s_if.tvalid = 1'b0; s_if.tdata = mk(16'hdead);
        step();
      end
    end
    s_if.tvalid = 1'b0;
  endtask

  // Drains one readout with tready high pct% of cycles, starting in the cycle READOUT appears.
  task automatic collect(input int pct, input int budget);
    logic [DWIDTH-1:0] pd;
    logic pv, pr, pl;
    rx.delete(); rx_last.delete();
    done_cnt = 0; stall_viol = 0; cycles = 0; first_valid = -1;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
    while (rx.size() < int'(DEPTH) && cycles < budget) begin
      if (done_o) done_cnt++;
      if (pv && !pr && (m_if.tvalid !== 1'b1 || m_if.tdata !== pd || m_if.tlast !== pl))
        stall_viol++;
      if (m_if.tvalid && first_valid < 0) first_valid = cycles;
      m_if.tready = (int'($urandom_range(0, 99)) < pct);
      if (m_if.tvalid && m_if.tready) begin
        rx.push_back(m_if.tdata);
        rx_last.push_back(m_if.tlast);
      end
      pv = m_if.tvalid; pr = m_if.tready; pd = m_if.tdata; pl = m_if.tlast;
      step();
      cycles++;
    end
    done_end  = done_o;
    state_end = state_o;
    m_if.tready = 1'b1;
    step();
    done_after = done_o;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (state_o !== 2'd0) begin miscompares++;
      $display("FAIL reset state: got %0d, want 0", state_o); end
    vectors++; if (m_if.tvalid !== 1'b0) begin miscompares++;
      $display("FAIL reset tvalid: got %b, want 0", m_if.tvalid); end
    vectors++; if (m_if.tlast !== 1'b0) begin miscompares++;
      $display("FAIL reset tlast: got %b, want 0", m_if.tlast); end
    vectors++; if (m_if.tdata !== '0) begin miscompares++;
      $display("FAIL reset tdata: got %0h, want 0", m_if.tdata); end
    vectors++; if (done_o !== 1'b0) begin miscompares++;
      $display("FAIL reset done: got %b, want 0", done_o); end
    vectors++; if (s_if.tready !== 1'b1) begin miscompares++;
      $display("FAIL reset s_tready: got %b, want 1", s_if.tready); end
    // Asynchronous reset in the middle of a stalled readout.
    arm();
    capture(50, 1'b0);
    m_if.tready = 1'b0;
    step(); step(); step();
    vectors++; if (m_if.tvalid !== 1'b1 || m_if.tdata !== mk(50)) begin miscompares++;
      $display("FAIL stalled head: got %b/%0h, want 1/%0h", m_if.tvalid, m_if.tdata, mk(50)); end
    #2 rst_i = 1'b1;
    #1;
    vectors++; if (state_o !== 2'd0 || m_if.tvalid !== 1'b0 || m_if.tdata !== '0) begin
      miscompares++;
      $display("FAIL async reset: got state %0d tvalid %b tdata %0h, want 0/0/0",
               state_o, m_if.tvalid, m_if.tdata); end
    rst_i = 1'b0;
    step();
  endtask

  task automatic test_basic();
    do_reset();
    arm();
    vectors++; if (state_o !== 2'd1) begin miscompares++;
      $display("FAIL basic armed: got %0d, want 1", state_o); end
    capture(0, 1'b0);
    vectors++; if (state_o !== 2'd3) begin miscompares++;
      $display("FAIL basic readout entry: got %0d, want 3", state_o); end
    collect(100, 100);
    vectors++; if (rx.size() != int'(DEPTH)) begin miscompares++;
      $display("FAIL basic count: got %0d, want %0d", rx.size(), DEPTH); end
    for (int i = 0; i < rx.size(); i++) begin
      vectors++; if (rx[i] !== mk(i)) begin miscompares++;
        $display("FAIL basic beat %0d: got %0h, want %0h", i, rx[i], mk(i)); end
      vectors++; if (rx_last[i] !== (i == int'(DEPTH) - 1)) begin miscompares++;
        $display("FAIL basic tlast %0d: got %b", i, rx_last[i]); end
    end
    vectors++; if (first_valid != 2) begin miscompares++;
      $display("FAIL basic latency: got %0d, want 2", first_valid); end
    vectors++; if (cycles != int'(DEPTH) + 2) begin miscompares++;
      $display("FAIL basic duration: got %0d, want %0d", cycles, DEPTH + 2); end
    vectors++; if (done_end !== 1'b1 || done_cnt != 0 || done_after !== 1'b0) begin
      miscompares++;
      $display("FAIL basic done pulse: got end %b early %0d after %b, want 1/0/0",
               done_end, done_cnt, done_after); end
    vectors++; if (state_end !== EndState) begin miscompares++;
      $display("FAIL basic end state: got %0d, want %0d", state_end, EndState); end
  endtask

  task automatic test_gapped();
    do_reset();
    arm();
    // Valid beat before the trigger must be discarded.
    s_if.tvalid = 1'b1; s_if.tdata = mk(999);
    step(); step();
    vectors++; if (state_o !== 2'd1) begin miscompares++;
      $display("FAIL gapped pre-trigger state: got %0d, want 1", state_o); end
    capture(100, 1'b1);
    vectors++; if (state_o !== 2'd3) begin miscompares++;
      $display("FAIL gapped readout entry: got %0d, want 3", state_o); end
    collect(100, 100);
    vectors++; if (rx.size() != int'(DEPTH)) begin miscompares++;
      $display("FAIL gapped count: got %0d, want %0d", rx.size(), DEPTH); end
    for (int i = 0; i < rx.size(); i++) begin
      vectors++; if (rx[i] !== mk(100 + i)) begin miscompares++;
        $display("FAIL gapped beat %0d: got %0h, want %0h", i, rx[i], mk(100 + i)); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    arm();
    capture(200, 1'b0);
    s_if.tvalid = 1'b1; s_if.tdata = mk(777);  // beats during readout must be ignored
    collect(30, 600);
    s_if.tvalid = 1'b0;
    vectors++; if (rx.size() != int'(DEPTH)) begin miscompares++;
      $display("FAIL bp count: got %0d, want %0d", rx.size(), DEPTH); end
    for (int i = 0; i < rx.size(); i++) begin
      vectors++; if (rx[i] !== mk(200 + i)) begin miscompares++;
        $display("FAIL bp beat %0d: got %0h, want %0h", i, rx[i], mk(200 + i)); end
      vectors++; if (rx_last[i] !== (i == int'(DEPTH) - 1)) begin miscompares++;
        $display("FAIL bp tlast %0d: got %b", i, rx_last[i]); end
    end
    vectors++; if (stall_viol != 0) begin miscompares++;
      $display("FAIL bp stability: got %0d violations, want 0", stall_viol); end
    vectors++; if (done_end !== 1'b1 || done_cnt != 0) begin miscompares++;
      $display("FAIL bp done: got end %b early %0d, want 1/0", done_end, done_cnt); end
  endtask

  task automatic test_edge_only();
    do_reset();
    trig_i = 1'b1;
    step(); step();
    arm();
    s_if.tvalid = 1'b1; s_if.tdata = mk(888);
    step(); step(); step();
    vectors++; if (state_o !== 2'd1) begin miscompares++;
      $display("FAIL edge held-high: got %0d, want 1", state_o); end
    trig_i = 1'b0;
    step();
    vectors++; if (state_o !== 2'd1) begin miscompares++;
      $display("FAIL edge falling: got %0d, want 1", state_o); end
    capture(300, 1'b0);
    vectors++; if (state_o !== 2'd3) begin miscompares++;
      $display("FAIL edge readout entry: got %0d, want 3", state_o); end
    collect(100, 100);
    vectors++; if (rx.size() != int'(DEPTH)) begin miscompares++;
      $display("FAIL edge count: got %0d, want %0d", rx.size(), DEPTH); end
    for (int i = 0; i < rx.size(); i++) begin
      vectors++; if (rx[i] !== mk(300 + i)) begin miscompares++;
        $display("FAIL edge beat %0d: got %0h, want %0h", i, rx[i], mk(300 + i)); end
    end
  endtask

  task automatic test_arm_with_edge();
    do_reset();
    arm_i = 1'b1; trig_i = 1'b1; s_if.tvalid = 1'b1; s_if.tdata = mk(42);
    step();
    arm_i = 1'b0;
    vectors++; if (state_o !== 2'd1) begin miscompares++;
      $display("FAIL arm+edge state: got %0d, want 1", state_o); end
    step(); step();
    vectors++; if (state_o !== 2'd1) begin miscompares++;
      $display("FAIL arm+edge later: got %0d, want 1", state_o); end
    s_if.tvalid = 1'b0;
  endtask

  task automatic test_abort();
    int n;
    do_reset();
    arm();
    capture(400, 1'b0);
    m_if.tready = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && n < 5; c++) begin
      if (m_if.tvalid) n++;
      step();
    end
    vectors++; if (m_if.tvalid !== 1'b1 || m_if.tdata !== mk(405)) begin miscompares++;
      $display("FAIL abort beat5: got %b/%0h, want 1/%0h", m_if.tvalid, m_if.tdata, mk(405)); end
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    vectors++; if (m_if.tvalid !== 1'b0 || state_o !== 2'd0 || done_o !== 1'b0) begin
      miscompares++;
      $display("FAIL abort effect: got tvalid %b state %0d done %b, want 0/0/0",
               m_if.tvalid, state_o, done_o); end
    n = 0;
    for (int c = 0; c < 4; c++) begin
      if (done_o || m_if.tvalid) n++;
      step();
    end
    vectors++; if (n != 0) begin miscompares++;
      $display("FAIL abort quiet: got %0d active cycles, want 0", n); end
    trig_i = 1'b0;
    arm();
    capture(500, 1'b0);
    collect(100, 100);
    vectors++; if (rx.size() != int'(DEPTH)) begin miscompares++;
      $display("FAIL abort recapture count: got %0d, want %0d", rx.size(), DEPTH); end
    for (int i = 0; i < rx.size(); i++) begin
      vectors++; if (rx[i] !== mk(500 + i)) begin miscompares++;
        $display("FAIL abort recapture beat %0d: got %0h, want %0h", i, rx[i], mk(500 + i)); end
    end
    vectors++; if (done_end !== 1'b1) begin miscompares++;
      $display("FAIL abort recapture done: got %b, want 1", done_end); end
  endtask

  task automatic test_rearm();
    do_reset();
    arm();
    capture(600, 1'b0);
    collect(100, 100);
    vectors++; if (state_end !== EndState) begin miscompares++;
      $display("FAIL rearm end state: got %0d, want %0d", state_end, EndState); end
    trig_i = 1'b0;
    step();
    capture(700, 1'b0);
`ifdef CAPBUF_AUTO_REARM_EN
    vectors++; if (state_o !== 2'd3) begin miscompares++;
      $display("FAIL rearm second capture: got %0d, want 3", state_o); end
    collect(100, 100);
    vectors++; if (rx.size() != int'(DEPTH)) begin miscompares++;
      $display("FAIL rearm count: got %0d, want %0d", rx.size(), DEPTH); end
    for (int i = 0; i < rx.size(); i++) begin
      vectors++; if (rx[i] !== mk(700 + i)) begin miscompares++;
        $display("FAIL rearm beat %0d: got %0h, want %0h", i, rx[i], mk(700 + i)); end
    end
    vectors++; if (done_end !== 1'b1 || state_end !== 2'd1) begin miscompares++;
      $display("FAIL rearm second end: got done %b state %0d, want 1/1", done_end, state_end); end
`else
    step(); step();
    vectors++; if (state_o !== 2'd0 || m_if.tvalid !== 1'b0) begin miscompares++;
      $display("FAIL no-rearm trigger: got state %0d tvalid %b, want 0/0",
               state_o, m_if.tvalid); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_backpressure();
    test_edge_only();
    test_arm_with_edge();
    test_abort();
    test_rearm();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
